// File: rtl/exec_step_controller.sv
// Execution sequencer for the lab datapath: produces the one-cycle cpu_en pulse
// in IDLE / single-STEP / divided RUN / BREAK-on-PC modes.
module exec_step_controller #(
   parameter int unsigned NBITS_PC = 8,
   parameter int unsigned RUN_DIV  = 4,
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                clk_2,
   input  logic                reset,
   input  logic                step_btn,
   input  logic                run_sw,
   input  logic                halt_req,
   input  logic                bp_en,
   input  logic [NBITS_PC-1:0] bp_addr,
   input  logic [NBITS_PC-1:0] pc,
   output logic                cpu_en,
   output logic [1:0]          state,
   output logic                bp_hit,
   output logic [CNT_BITS-1:0] instr_count
);

   localparam int unsigned DIV_BITS = $clog2(RUN_DIV);
   localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(RUN_DIV - 1);

   localparam logic [1:0] StIdle  = 2'b00;
   localparam logic [1:0] StStep  = 2'b01;
   localparam logic [1:0] StRun   = 2'b10;
   localparam logic [1:0] StBreak = 2'b11;

   logic [1:0]          state_q, state_d;
   logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
   logic                s1_q, s2_q, s3_q;
   logic                cpu_en_q;
   logic                bp_hit_q;
   logic [CNT_BITS-1:0] instr_count_q, instr_count_d;
   logic                step_pulse;
   logic                run_pulse;

   // Rising edge of the synchronized button; a long hold yields one pulse.
   assign step_pulse = s2_q & ~s3_q;

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      run_pulse = 1'b0;
      unique case (state_q)
         StIdle: begin
            div_cnt_d = '0;
            if (halt_req) begin
               state_d = StIdle;
            end else if (step_pulse) begin
               state_d = StStep;
            end else if (run_sw) begin
               state_d = StRun;
            end
         end
         StStep: begin
            div_cnt_d = '0;
            state_d   = StIdle;
         end
         StRun: begin
            if (halt_req || !run_sw) begin
               state_d   = StIdle;
               div_cnt_d = '0;
            end else if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               // pc only moves after a pulse, so this compares the next fetch address
               if (bp_en && (pc == bp_addr)) begin
                  state_d = StBreak;
               end else begin
                  run_pulse = 1'b1;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         StBreak: begin
            div_cnt_d = '0;
            if (halt_req || !run_sw) begin
               state_d = StIdle;
            end else if (step_pulse) begin
               state_d = StStep;
            end
         end
         default: begin
            state_d   = StIdle;
            div_cnt_d = '0;
         end
      endcase
   end

   assign instr_count_d = cpu_en_q ? instr_count_q + 1'b1 : instr_count_q;

   always_ff @(posedge clk_2) begin
      if (!reset) begin
         state_q       <= StIdle;
         div_cnt_q     <= '0;
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         cpu_en_q      <= 1'b0;
         bp_hit_q      <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         s1_q          <= step_btn;
         s2_q          <= s1_q;
         s3_q          <= s2_q;
         cpu_en_q      <= (state_d == StStep) | run_pulse;
         bp_hit_q      <= (state_d == StBreak);
         instr_count_q <= instr_count_d;
      end
   end

   assign cpu_en      = cpu_en_q;
   assign state       = state_q;
   assign bp_hit      = bp_hit_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Directed bench for exec_step_controller: a cycle table for step/halt/run
// basics plus hand sequences for free-run, breakpoint, halt, wrap and reset.
module tb_exec_step_controller;

   logic        clk_2 = 1'b0;
   logic        reset;
   logic        step_btn;
   logic        run_sw;
   logic        halt_req;
   logic        bp_en;
   logic [7:0]  bp_addr;
   logic [7:0]  pc;
   logic        pc_clr;
   logic        cpu_en;
   logic [1:0]  state;
   logic        bp_hit;
   logic [15:0] instr_count;
   logic        cpu_en_w;
   logic [1:0]  state_w;
   logic        bp_hit_w;
   logic [3:0]  cnt_w;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   always #5 clk_2 = ~clk_2;

   exec_step_controller #(.NBITS_PC(8), .RUN_DIV(4), .CNT_BITS(16)) dut (
      .clk_2(clk_2), .reset(reset), .step_btn(step_btn), .run_sw(run_sw),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .instr_count(instr_count)
   );

   exec_step_controller #(.NBITS_PC(8), .RUN_DIV(4), .CNT_BITS(4)) dut_w (
      .clk_2(clk_2), .reset(reset), .step_btn(step_btn), .run_sw(run_sw),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .cpu_en(cpu_en_w), .state(state_w), .bp_hit(bp_hit_w), .instr_count(cnt_w)
   );

   // Datapath PC model: advances by 4 after every enable pulse.
   always @(posedge clk_2) begin
      if (pc_clr) pc <= 8'h00;
      else if (cpu_en) pc <= pc + 8'h04;
   end

   typedef struct {
      logic       btn;
      logic       run;
      logic       halt;
      logic [1:0] st;
      logic       en;
      int         cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic b, input logic r, input logic h, input logic [1:0] s,
                      input logic e, input int c);
      vec_t v;
      v = '{b, r, h, s, e, c};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_2);
      #1;
      if (cpu_en) pulses++;
   endtask

   task automatic do_reset();
      step_btn = 1'b0; run_sw = 1'b0; halt_req = 1'b0; bp_en = 1'b0; bp_addr = 8'h00;
      reset = 1'b0; pc_clr = 1'b1;
      tick(); tick();
      reset = 1'b1; pc_clr = 1'b0;
   endtask

   task automatic press();
      step_btn = 1'b1;
      repeat (4) tick();
      step_btn = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit found;
      // Reset dominates a held button and run request
      reset = 1'b0; pc_clr = 1'b1; step_btn = 1'b1; run_sw = 1'b1;
      halt_req = 1'b0; bp_en = 1'b0; bp_addr = 8'h00;
      tick(); tick();
      check("reset state", 32'(state), 0);
      check("reset cpu_en", 32'(cpu_en), 0);
      check("reset bp_hit", 32'(bp_hit), 0);
      check("reset count", 32'(instr_count), 0);
      check("reset count_w", 32'(cnt_w), 0);
      step_btn = 1'b0; run_sw = 1'b0; reset = 1'b1; pc_clr = 1'b0;
      repeat (3) tick();
      check("post-reset idle", 32'(state), 0);

      // btn, run, halt -> state, cpu_en, instr_count after the edge
      add(1, 0, 0, 2'd0, 0, 0); add(1, 0, 0, 2'd0, 0, 0); add(1, 0, 0, 2'd1, 1, 0);
      add(1, 0, 0, 2'd0, 0, 1); add(1, 0, 0, 2'd0, 0, 1); add(0, 0, 0, 2'd0, 0, 1);
      add(0, 0, 0, 2'd0, 0, 1); add(0, 0, 0, 2'd0, 0, 1);
      add(1, 0, 1, 2'd0, 0, 1); add(1, 0, 1, 2'd0, 0, 1); add(1, 0, 1, 2'd0, 0, 1);
      add(1, 0, 0, 2'd0, 0, 1); add(0, 0, 0, 2'd0, 0, 1); add(0, 0, 0, 2'd0, 0, 1);
      add(0, 0, 0, 2'd0, 0, 1);
      add(1, 0, 0, 2'd0, 0, 1); add(1, 0, 0, 2'd0, 0, 1); add(1, 0, 0, 2'd1, 1, 1);
      add(0, 0, 0, 2'd0, 0, 2); add(0, 0, 0, 2'd0, 0, 2); add(0, 0, 0, 2'd0, 0, 2);
      add(0, 1, 1, 2'd0, 0, 2); add(0, 1, 0, 2'd2, 0, 2); add(0, 1, 0, 2'd2, 0, 2);
      add(0, 1, 0, 2'd2, 0, 2); add(0, 1, 0, 2'd2, 0, 2); add(0, 1, 0, 2'd2, 1, 2);
      add(0, 1, 0, 2'd2, 0, 3); add(0, 1, 1, 2'd0, 0, 3); add(0, 0, 0, 2'd0, 0, 3);
      foreach (vecs[i]) begin
         step_btn = vecs[i].btn; run_sw = vecs[i].run; halt_req = vecs[i].halt;
         tick();
         check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("vec%0d cpu_en", i), 32'(cpu_en), 32'(vecs[i].en));
         check($sformatf("vec%0d count", i), 32'(instr_count), 32'(vecs[i].cnt));
      end

      // Free run: pulses every 4 cycles, stop cleanly on run_sw=0
      do_reset();
      begin
         int last;
         int npul;
         last = -1; npul = 0;
         run_sw = 1'b1;
         for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (cpu_en) begin
               if (last >= 0) check("run pulse gap", 32'(cyc - last), 4);
               last = cyc;
               npul++;
            end
         end
         check("run pulse total", 32'(npul), 9);
         run_sw = 1'b0;
         tick();
         check("run stop state", 32'(state), 0);
         check("run stop cpu_en", 32'(cpu_en), 0);
         pulses = 0;
         repeat (10) tick();
         check("run stop no pulses", 32'(pulses), 0);
      end

      // Breakpoint at 0x08
      do_reset();
      bp_en = 1'b1; bp_addr = 8'h08; run_sw = 1'b1; pulses = 0;
      found = 1'b0;
      for (int cyc = 0; cyc < 40 && !found; cyc++) begin
         tick();
         if (state == 2'b11) found = 1'b1;
      end
      check("bp reached", 32'(found), 1);
      check("bp pulses before", 32'(pulses), 2);
      check("bp pc", 32'(pc), 32'h08);
      check("bp hit", 32'(bp_hit), 1);
      check("bp count", 32'(instr_count), 2);
      pulses = 0;
      repeat (50) tick();
      check("bp held no pulses", 32'(pulses), 0);
      check("bp held state", 32'(state), 3);
      step_btn = 1'b1;
      found = 1'b0;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
         tick();
         if (cpu_en) found = 1'b1;
      end
      check("bp step pulse seen", 32'(found), 1);
      check("bp step state", 32'(state), 1);
      tick();
      check("bp step pc", 32'(pc), 32'h0C);
      check("bp cleared", 32'(bp_hit), 0);
      check("bp step then idle", 32'(state), 0);
      found = 1'b0;
      for (int cyc = 0; cyc < 5 && !found; cyc++) begin
         tick();
         if (state == 2'b10) found = 1'b1;
      end
      check("bp run resumed", 32'(found), 1);
      found = 1'b0;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
         tick();
         if (cpu_en) found = 1'b1;
      end
      check("bp resume pulse", 32'(found), 1);
      check("bp resume pc", 32'(pc), 32'h0C);
      check("bp resume state", 32'(state), 2);
      step_btn = 1'b0;

      // Halt in RUN, then resume
      halt_req = 1'b1;
      tick();
      check("halt run state", 32'(state), 0);
      pulses = 0;
      repeat (8) tick();
      check("halt no pulses", 32'(pulses), 0);
      check("halt held state", 32'(state), 0);
      halt_req = 1'b0;
      tick();
      check("halt release run", 32'(state), 2);

      // Counter wrap on the 4-bit instance
      do_reset();
      repeat (17) press();
      check("wrap count 4b", 32'(cnt_w), 1);
      check("wrap count 16b", 32'(instr_count), 17);

      // Reset on the edge where a RUN pulse would have been issued
      run_sw = 1'b1;
      tick();
      check("pre-reset run", 32'(state), 2);
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      check("midrun reset state", 32'(state), 0);
      check("midrun reset cpu_en", 32'(cpu_en), 0);
      check("midrun reset count", 32'(instr_count), 0);
      reset = 1'b1; run_sw = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
